time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_pkg.sv | 21 ++
 rtl/bcd_mod_counter.sv | 61 ++++++
 rtl/time_keeper.sv | 133 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the time_keeper clock.
// Provides the BCD digit type, range limits and digit-split helpers.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HR24_MAX = 23;
    localparam int unsigned HR12_MIN = 1;
    localparam int unsigned HR12_MAX = 12;

    function automatic bcd_t bcd_tens(input int unsigned v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t bcd_ones(input int unsigned v);
        return bcd_t'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with programmable min/max and wrap-to-min.
// Ports: clk, clr (sync, active-high, loads RST_*), inc, load_min,
//        min_tens/min_ones, max_tens/max_ones, tens/ones (registered), carry.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd_t RST_TENS = '0,
    parameter bcd_t RST_ONES = '0
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic load_min,
    input  bcd_t min_tens,
    input  bcd_t min_ones,
    input  bcd_t max_tens,
    input  bcd_t max_ones,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        at_max = (tens_q == max_tens) && (ones_q == max_ones);
        carry  = inc && at_max && !load_min;
        if (load_min) begin
            tens_d = min_tens;
            ones_d = min_ones;
        end else if (inc) begin
            if (at_max) begin
                tens_d = min_tens;
                ones_d = min_ones;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tens_q <= RST_TENS;
            ones_q <= RST_ONES;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/time_keeper.sv
// Real-time clock: prescaler, binary seconds, BCD minutes and hours.
// Ports: clk, clr (sync, active-high), run, set_hr, set_min,
//        in1..in4 (hour tens/ones, minute tens/ones), sec_tick, pm.
// Macro TWELVE_HOUR_EN selects 12 h mode (12,01..11) with pm flag;
// default build is 24 h (00..23) with pm tied 0.
module time_keeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic set_hr,
    input  logic set_min,
    output bcd_t in1,
    output bcd_t in2,
    output bcd_t in3,
    output bcd_t in4,
    output logic sec_tick,
    output logic pm
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

`ifdef TWELVE_HOUR_EN
    localparam int unsigned HR_LO  = HR12_MIN;
    localparam int unsigned HR_HI  = HR12_MAX;
    localparam int unsigned HR_RST = HR12_MAX;
`else
    localparam int unsigned HR_LO  = 0;
    localparam int unsigned HR_HI  = HR24_MAX;
    localparam int unsigned HR_RST = 0;
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic          sec_tick_q, sec_tick_d;
    logic          pm_q, pm_d;

    logic tick;
    logic adv;
    logic sec_wrap;
    logic min_inc;
    logic min_carry;
    logic hr_inc;
    logic hr_carry_unused;

    always_comb begin
        tick     = run && (presc_q == PRESC_LAST);
        // A set pulse steals the tick: time does not advance this cycle.
        adv      = tick && !set_hr && !set_min;
        sec_wrap = adv && (sec_q == 6'(SEC_MAX));
        min_inc  = set_min || sec_wrap;
        // Minute wrap from set_min must not ripple into hours.
        hr_inc   = set_hr || (min_carry && !set_min);

        presc_d = presc_q;
        if (set_min) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        sec_d = sec_q;
        if (set_min) begin
            sec_d = '0;
        end else if (adv) begin
            sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
        end

        sec_tick_d = tick;

`ifdef TWELVE_HOUR_EN
        pm_d = pm_q ^ (hr_inc && in1 == 4'd1 && in2 == 4'd1);
`else
        pm_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q    <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
            pm_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            pm_q       <= pm_d;
        end
    end

    bcd_mod_counter #(
        .RST_TENS (4'd0),
        .RST_ONES (4'd0)
    ) u_min (
        .clk      (clk),
        .clr      (clr),
        .inc      (min_inc),
        .load_min (1'b0),
        .min_tens (4'd0),
        .min_ones (4'd0),
        .max_tens (bcd_tens(MIN_MAX)),
        .max_ones (bcd_ones(MIN_MAX)),
        .tens     (in3),
        .ones     (in4),
        .carry    (min_carry)
    );

    bcd_mod_counter #(
        .RST_TENS (bcd_tens(HR_RST)),
        .RST_ONES (bcd_ones(HR_RST))
    ) u_hr (
        .clk      (clk),
        .clr      (clr),
        .inc      (hr_inc),
        .load_min (1'b0),
        .min_tens (bcd_tens(HR_LO)),
        .min_ones (bcd_ones(HR_LO)),
        .max_tens (bcd_tens(HR_HI)),
        .max_ones (bcd_ones(HR_HI)),
        .tens     (in1),
        .ones     (in2),
        .carry    (hr_carry_unused)
    );

    assign sec_tick = sec_tick_q;
    assign pm       = pm_q;

endmodule
